image_blitter: RTL and testbench
================================

IMAGE_BLITTER -- requirements
Module: image_blitter

Interface
REQ-001 Parameter IMG_W, 320, image width in pixels.
REQ-002 Parameter IMG_H, 240, image height in pixels; IMG_W*IMG_H SHALL be <= 131072.
REQ-003 Parameter SCREEN_W, 320, visible screen width; SCREEN_H, 240, visible screen height.
REQ-004 Parameter KEY_EN, 0, when 1 enables transparent-colour suppression; KEY_COLOUR, 8'h00, transparent colour value.
REQ-005 clock  input  1  single system clock, all logic rising-edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle request to draw the image once.
REQ-008 x0  input  9  screen column of image top-left, sampled on accepted start.
REQ-009 y0  input  8  screen row of image top-left, sampled on accepted start.
REQ-010 rdaddress  output  17  registered read address to image RAM (1-cycle read latency, unregistered q).
REQ-011 q  input  8  image RAM read data, valid the cycle after rdaddress is sampled by the RAM.
REQ-012 x  output  9  pixel column to VGA adapter.
REQ-013 y  output  8  pixel row to VGA adapter.
REQ-014 colour  output  8  pixel colour to VGA adapter.
REQ-015 plot  output  1  VGA write enable, one pixel per cycle.
REQ-016 busy  output  1  high while a draw is in progress.
REQ-017 done  output  1  one-cycle pulse marking the final pixel output slot.

Function
REQ-018 States SHALL be IDLE, READ, DRAIN; only IDLE accepts start.
REQ-019 IDLE + start=1 at edge S: latch x0/y0, rdaddress<=0, col=row=0, busy<=1, go READ.
REQ-020 start while busy SHALL be ignored (no restart, no latch of x0/y0).
REQ-021 READ: each cycle rdaddress increments by 1; col increments, wraps to 0 at IMG_W-1 with row+1; no multiplier used.
REQ-022 READ: after driving address IMG_W*IMG_H-1 (edge S+N-1, N=IMG_W*IMG_H), go DRAIN; rdaddress holds last value.
REQ-023 Pipeline: pixel at address A SHALL appear on x/y/colour/plot exactly 2 cycles after rdaddress first equals A; col/row delayed to match.
REQ-024 Output x = x0+col, y = y0+row computed at 10/9-bit width before truncation; colour = q registered.
REQ-025 plot SHALL be 0 for a pixel if x0+col >= SCREEN_W or y0+row >= SCREEN_H (clipping, no wrap-around onto screen).
REQ-026 plot SHALL be 0 for a pixel if KEY_EN=1 and q==KEY_COLOUR; x/y/colour still update.
REQ-027 Otherwise plot=1 for exactly one cycle per pixel, pixels in raster order, no gaps.
REQ-028 done SHALL be 1 in the same cycle as the output slot of address N-1 (edge S+N+1), regardless of that pixel's plot value.
REQ-029 DRAIN: after done cycle return to IDLE; busy<=0 at edge S+N+2; start accepted again that cycle onward.
REQ-030 IDLE: plot=0, done=0, x/y/colour hold last values.

Reset
REQ-031 resetn=0 SHALL immediately force IDLE, rdaddress=0, x=0, y=0, colour=0, plot=0, busy=0, done=0, clear pipeline valid bits.
REQ-032 Reset mid-draw SHALL abort with no further plot pulses; first start after resetn=1 begins a fresh draw from address 0.

Verification (IMG_W=4, IMG_H=2, RAM model mem[A]=A+1 unless stated)
REQ-033 start, x0=10, y0=20 -> rdaddress 0..7 on consecutive cycles; plot 8 cycles from S+2, (x,y,colour)=(10,20,1)..(13,21,8); done at S+9; busy low at S+10.
REQ-034 x0=318, y0=239 -> plot only for (318,239,1),(319,239,2); other 6 slots plot=0; done still at S+9.
REQ-035 KEY_EN=1, KEY_COLOUR=3, mem[A]=A+1 -> plot=0 only for address 2 slot, 7 plots total.
REQ-036 second start at S+4 -> ignored, exactly 8 output slots, x0/y0 unchanged; start at S+10 -> new draw.
REQ-037 resetn low at S+5 for 1 cycle -> outputs zero immediately, no plot afterwards until next start; next draw produces full 8 pixels correctly.

Source files
------------

// File: rtl/image_blitter.sv
// Streams an IMG_W x IMG_H image out of a 1-cycle-latency RAM onto a VGA pixel port.
// Each pixel is placed at (x0,y0)+(col,row) and may be clipped or colour-keyed.
module image_blitter #(
  parameter int unsigned IMG_W      = 320,
  parameter int unsigned IMG_H      = 240,
  parameter int unsigned SCREEN_W   = 320,
  parameter int unsigned SCREEN_H   = 240,
  parameter bit          KEY_EN     = 1'b0,
  parameter logic [7:0]  KEY_COLOUR = 8'h00
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [8:0]  x0,
  input  logic [7:0]  y0,
  output logic [16:0] rdaddress,
  input  logic [7:0]  q,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [7:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW    = 17;
  localparam int unsigned SW    = AW + 1;
  localparam int unsigned PIX_N = IMG_W * IMG_H;

  localparam logic [AW-1:0] PENULT_ADDR = AW'(PIX_N - 2);
  localparam logic [AW-1:0] COL_MAX     = AW'(IMG_W - 1);
  localparam bit            SINGLE_PIX  = (PIX_N == 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          state;
  logic [8:0]      x0_r;
  logic [7:0]      y0_r;
  logic [AW-1:0]   col;
  logic [AW-1:0]   row;
  logic            a_valid;
  logic            a_last;

  logic            b_valid;
  logic            b_last;
  logic [AW-1:0]   b_col;
  logic [AW-1:0]   b_row;

  logic [SW-1:0]   x_sum;
  logic [SW-1:0]   y_sum;
  logic            on_screen;
  logic            keyed;

  // Address generator and control FSM; col/row track rdaddress without a multiply.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rdaddress <= '0;
      x0_r      <= '0;
      y0_r      <= '0;
      col       <= '0;
      row       <= '0;
      a_valid   <= 1'b0;
      a_last    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a_valid <= 1'b0;
          a_last  <= 1'b0;
          if (start) begin
            x0_r      <= x0;
            y0_r      <= y0;
            rdaddress <= '0;
            col       <= '0;
            row       <= '0;
            a_valid   <= 1'b1;
            a_last    <= SINGLE_PIX;
            busy      <= 1'b1;
            state     <= SINGLE_PIX ? DRAIN : READ;
          end
        end
        READ: begin
          rdaddress <= rdaddress + AW'(1);
          a_valid   <= 1'b1;
          a_last    <= (rdaddress == PENULT_ADDR);
          if (col == COL_MAX) begin
            col <= '0;
            row <= row + AW'(1);
          end else begin
            col <= col + AW'(1);
          end
          if (rdaddress == PENULT_ADDR) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          a_valid <= 1'b0;
          a_last  <= 1'b0;
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          a_valid <= 1'b0;
          a_last  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Delay col/row one cycle so they line up with q from the RAM.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      b_valid <= 1'b0;
      b_last  <= 1'b0;
      b_col   <= '0;
      b_row   <= '0;
    end else begin
      b_valid <= a_valid;
      b_last  <= a_valid && a_last;
      b_col   <= col;
      b_row   <= row;
    end
  end

  // Screen position is formed wider than the ports so off-screen pixels never wrap.
  always_comb begin
    x_sum     = SW'(x0_r) + SW'(b_col);
    y_sum     = SW'(y0_r) + SW'(b_row);
    on_screen = (x_sum < SW'(SCREEN_W)) && (y_sum < SW'(SCREEN_H));
    keyed     = KEY_EN && (q == KEY_COLOUR);
  end

  // Pixel output stage; x/y/colour hold between draws.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      done   <= 1'b0;
    end else begin
      plot <= b_valid && on_screen && !keyed;
      done <= b_last;
      if (b_valid) begin
        x      <= x_sum[8:0];
        y      <= y_sum[7:0];
        colour <= q;
      end
    end
  end

endmodule

// File: tb/tb_image_blitter.sv
// Directed checks of image_blitter on a 4x2 image with a RAM holding mem[A]=A+1.
module tb_image_blitter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        start_k;
  logic [8:0]  x0;
  logic [7:0]  y0;

  logic [16:0] rdaddress, rdaddress_k;
  logic [7:0]  q = 8'd0;
  logic [7:0]  q_k = 8'd0;
  logic [8:0]  x, x_k;
  logic [7:0]  y, y_k;
  logic [7:0]  colour, colour_k;
  logic        plot, plot_k, busy, busy_k, done, done_k;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  // Image RAM models: one-cycle registered read, contents A+1.
  always @(posedge clock) begin
    q   <= 8'(rdaddress + 17'd1);
    q_k <= 8'(rdaddress_k + 17'd1);
  end

  image_blitter #(
    .IMG_W(4), .IMG_H(2), .SCREEN_W(320), .SCREEN_H(240),
    .KEY_EN(1'b0), .KEY_COLOUR(8'h00)
  ) u_dut (
    .clock(clock), .resetn(resetn), .start(start), .x0(x0), .y0(y0),
    .rdaddress(rdaddress), .q(q), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  image_blitter #(
    .IMG_W(4), .IMG_H(2), .SCREEN_W(320), .SCREEN_H(240),
    .KEY_EN(1'b1), .KEY_COLOUR(8'h03)
  ) u_key (
    .clock(clock), .resetn(resetn), .start(start_k), .x0(x0), .y0(y0),
    .rdaddress(rdaddress_k), .q(q_k), .x(x_k), .y(y_k), .colour(colour_k),
    .plot(plot_k), .busy(busy_k), .done(done_k)
  );

  // Raise start for one edge (edge S); returns 1 time unit after edge S.
  task automatic fire(input bit use_key, input logic [8:0] px, input logic [7:0] py);
    @(negedge clock);
    x0 = px;
    y0 = py;
    if (use_key) start_k = 1'b1;
    else         start   = 1'b1;
    @(posedge clock);
    #1;
    start   = 1'b0;
    start_k = 1'b0;
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    start   = 1'b0;
    start_k = 1'b0;
    x0      = '0;
    y0      = '0;
    #2;
    total++;
    if ({rdaddress, x, y, colour, plot, busy, done} !== 52'd0)
      $display("FAIL reset_outputs got addr=%0d x=%0d y=%0d c=%0d p=%b b=%b d=%b want all 0",
               rdaddress, x, y, colour, plot, busy, done);
    else passed++;
    total++;
    if ({rdaddress_k, plot_k, busy_k, done_k} !== 20'd0)
      $display("FAIL reset_key_outputs got addr=%0d p=%b b=%b d=%b want all 0",
               rdaddress_k, plot_k, busy_k, done_k);
    else passed++;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    int plots = 0;
    int a;
    fire(1'b0, 9'd10, 8'd20);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      total++;
      if (rdaddress !== 17'((k <= 7) ? k : 7))
        $display("FAIL basic_addr k=%0d got %0d want %0d", k, rdaddress, (k <= 7) ? k : 7);
      else passed++;
      total++;
      if (busy !== (k <= 9)) $display("FAIL basic_busy k=%0d got %b want %b", k, busy, k <= 9);
      else passed++;
      total++;
      if (done !== (k == 9)) $display("FAIL basic_done k=%0d got %b want %b", k, done, k == 9);
      else passed++;
      if (k >= 2 && k <= 9) begin
        a = k - 2;
        if (plot === 1'b1) plots++;
        total++;
        if ({plot, x, y, colour} !== {1'b1, 9'(10 + a % 4), 8'(20 + a / 4), 8'(a + 1)})
          $display("FAIL basic_pixel A=%0d got p=%b (%0d,%0d,%0d) want p=1 (%0d,%0d,%0d)",
                   a, plot, x, y, colour, 10 + a % 4, 20 + a / 4, a + 1);
        else passed++;
      end else begin
        total++;
        if (plot !== 1'b0) $display("FAIL basic_noplot k=%0d got %b want 0", k, plot);
        else passed++;
      end
    end
    total++;
    if ({x, y, colour} !== {9'd13, 8'd21, 8'd8})
      $display("FAIL basic_hold got (%0d,%0d,%0d) want (13,21,8)", x, y, colour);
    else passed++;
    total++;
    if (plots != 8) $display("FAIL basic_plot_count got %0d want 8", plots);
    else passed++;
  endtask

  task automatic test_clip();
    int plots = 0;
    int a, ex, ey;
    bit eplot;
    fire(1'b0, 9'd318, 8'd239);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      total++;
      if (done !== (k == 9)) $display("FAIL clip_done k=%0d got %b want %b", k, done, k == 9);
      else passed++;
      if (k >= 2 && k <= 9) begin
        a     = k - 2;
        ex    = 318 + a % 4;
        ey    = 239 + a / 4;
        eplot = (ex < 320) && (ey < 240);
        if (plot === 1'b1) plots++;
        total++;
        if ({plot, x, y, colour} !== {eplot, 9'(ex), 8'(ey), 8'(a + 1)})
          $display("FAIL clip_pixel A=%0d got p=%b (%0d,%0d,%0d) want p=%b (%0d,%0d,%0d)",
                   a, plot, x, y, colour, eplot, ex, ey, a + 1);
        else passed++;
      end
    end
    total++;
    if (busy !== 1'b0) $display("FAIL clip_busy_end got %b want 0", busy);
    else passed++;
    total++;
    if (plots != 2) $display("FAIL clip_plot_count got %0d want 2", plots);
    else passed++;
  endtask

  task automatic test_key();
    int plots = 0;
    int a;
    fire(1'b1, 9'd10, 8'd20);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      total++;
      if (done_k !== (k == 9)) $display("FAIL key_done k=%0d got %b want %b", k, done_k, k == 9);
      else passed++;
      if (k >= 2 && k <= 9) begin
        a = k - 2;
        if (plot_k === 1'b1) plots++;
        total++;
        if ({plot_k, x_k, y_k, colour_k} !==
            {(a != 2), 9'(10 + a % 4), 8'(20 + a / 4), 8'(a + 1)})
          $display("FAIL key_pixel A=%0d got p=%b (%0d,%0d,%0d) want p=%b (%0d,%0d,%0d)",
                   a, plot_k, x_k, y_k, colour_k, a != 2, 10 + a % 4, 20 + a / 4, a + 1);
        else passed++;
      end
    end
    total++;
    if (plots != 7) $display("FAIL key_plot_count got %0d want 7", plots);
    else passed++;
  endtask

  // Start while busy is ignored; start once busy drops begins a new draw.
  task automatic test_back_to_back();
    int plots = 0;
    int s, a, bx, by;
    fire(1'b0, 9'd10, 8'd20);
    for (int k = 0; k <= 21; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      s  = (k < 11) ? k : k - 11;
      bx = (k < 11) ? 10 : 100;
      by = (k < 11) ? 20 : 5;
      if (k == 4 || k == 11) start = 1'b0;
      total++;
      if (rdaddress !== 17'((s <= 7) ? s : 7))
        $display("FAIL b2b_addr k=%0d got %0d want %0d", k, rdaddress, (s <= 7) ? s : 7);
      else passed++;
      total++;
      if ({busy, done} !== {(s <= 9), (s == 9)})
        $display("FAIL b2b_ctrl k=%0d got busy=%b done=%b want busy=%b done=%b",
                 k, busy, done, s <= 9, s == 9);
      else passed++;
      if (s >= 2 && s <= 9) begin
        a = s - 2;
        if (plot === 1'b1) plots++;
        total++;
        if ({plot, x, y, colour} !== {1'b1, 9'(bx + a % 4), 8'(by + a / 4), 8'(a + 1)})
          $display("FAIL b2b_pixel k=%0d got p=%b (%0d,%0d,%0d) want p=1 (%0d,%0d,%0d)",
                   k, plot, x, y, colour, bx + a % 4, by + a / 4, a + 1);
        else passed++;
      end
      if (k == 3) begin
        start = 1'b1;
        x0    = 9'd50;
        y0    = 8'd50;
      end
      if (k == 10) begin
        start = 1'b1;
        x0    = 9'd100;
        y0    = 8'd5;
      end
    end
    total++;
    if (plots != 16) $display("FAIL b2b_plot_count got %0d want 16", plots);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int plots = 0;
    int quiet_bad = 0;
    int a;
    fire(1'b0, 9'd10, 8'd20);
    repeat (5) begin @(posedge clock); #1; end
    resetn = 1'b0;
    #1;
    total++;
    if ({rdaddress, x, y, colour, plot, busy, done} !== 52'd0)
      $display("FAIL midreset_outputs got addr=%0d x=%0d y=%0d c=%0d p=%b b=%b d=%b want all 0",
               rdaddress, x, y, colour, plot, busy, done);
    else passed++;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) quiet_bad++;
    end
    total++;
    if (quiet_bad != 0) $display("FAIL midreset_quiet got %0d active cycles want 0", quiet_bad);
    else passed++;
    fire(1'b0, 9'd1, 8'd2);
    total++;
    if (rdaddress !== 17'd0) $display("FAIL midreset_restart_addr got %0d want 0", rdaddress);
    else passed++;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock);
      #1;
      if (k >= 2 && k <= 9) begin
        a = k - 2;
        if (plot === 1'b1) plots++;
        total++;
        if ({plot, x, y, colour} !== {1'b1, 9'(1 + a % 4), 8'(2 + a / 4), 8'(a + 1)})
          $display("FAIL midreset_pixel A=%0d got p=%b (%0d,%0d,%0d) want p=1 (%0d,%0d,%0d)",
                   a, plot, x, y, colour, 1 + a % 4, 2 + a / 4, a + 1);
        else passed++;
      end
      if (k == 9) begin
        total++;
        if (done !== 1'b1) $display("FAIL midreset_done got %b want 1", done);
        else passed++;
      end
    end
    total++;
    if (plots != 8 || busy !== 1'b0)
      $display("FAIL midreset_end got plots=%0d busy=%b want plots=8 busy=0", plots, busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_key();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
